// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the backing-memory responder behind the 2-way cache.
package cache_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mem_resp_t;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    longint unsigned limit;
    longint unsigned a;
    limit = longint'(depth) << 2;
    a     = longint'(addr);
    return (addr[1:0] != 2'b00) || (a >= limit);
  endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Word storage with per-word written flags; sync write, async read, flags cleared on reset.
module cache_mem_array
  import cache_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rwritten_o
);

  logic [DATA_W-1:0]      mem_q [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] written_q;

  // Contents are never cleared; the written flags shadow stale data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
    end else if (we_i) begin
      written_q[waddr_i] <= 1'b1;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign rwritten_o = written_q[raddr_i];

endmodule

// File: rtl/cache_backing_mem.sv
// Single-outstanding word responder: unwritten words read back their own byte address.
module cache_backing_mem
  import cache_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  mem_resp_t         resp_q;
  logic              resp_valid_q;
  logic              req_ready_q;

  mem_req_t          req_in;
  mem_resp_t         resp_d;
  logic              accept;
  logic              in_err;
  logic              wr_en;
  logic              lk_we;
  logic              lk_err;
  logic [ADDR_W-1:0] lk_addr;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_written;

  always_comb begin
    req_in       = '0;
    req_in.we    = req_we;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
  end

  assign accept = (state_q == IDLE) && req_valid && req_ready_q;
  assign in_err = addr_err(req_in.addr, DEPTH_WORDS);
  assign wr_en  = accept && req_in.we && !in_err && !rst;

  // With LATENCY=1 the response is built on the accept edge, so look up the live request.
  assign lk_addr = (state_q == IDLE) ? req_in.addr : addr_q;
  assign lk_we   = (state_q == IDLE) ? req_in.we   : we_q;
  assign lk_err  = (state_q == IDLE) ? in_err      : err_q;

  cache_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_en),
    .waddr_i   (req_in.addr[IDX_W+1:2]),
    .wdata_i   (req_in.wdata),
    .raddr_i   (lk_addr[IDX_W+1:2]),
    .rdata_o   (arr_rdata),
    .rwritten_o(arr_written)
  );

  always_comb begin
    resp_d     = '0;
    resp_d.err = lk_err;
    if (!lk_err && !lk_we) begin
      resp_d.rdata = arr_written ? arr_rdata : lk_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q        <= req_in.we;
            addr_q      <= req_in.addr;
            err_q       <= in_err;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_q       <= resp_d;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= RESP;
            resp_q       <= resp_d;
            resp_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_cache_backing_mem.sv
// Directed plus randomized bench for cache_backing_mem at LATENCY=3 and LATENCY=1.
module tb_cache_backing_mem;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        sel1;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;
  logic        req_valid0, req_valid1;

  int unsigned checks;
  int unsigned errors;

  logic [31:0] mdl0 [int unsigned];
  logic [31:0] mdl1 [int unsigned];

  assign req_valid0 = req_valid && !sel1;
  assign req_valid1 = req_valid && sel1;

  cache_backing_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  cache_backing_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rv(input bit d1);
    return d1 ? resp_valid1 : resp_valid0;
  endfunction
  function automatic logic rq(input bit d1);
    return d1 ? req_ready1 : req_ready0;
  endfunction
  function automatic logic er(input bit d1);
    return d1 ? resp_err1 : resp_err0;
  endfunction
  function automatic logic [31:0] rd(input bit d1);
    return d1 ? resp_rdata1 : resp_rdata0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; the exit negedge is the first IDLE cycle.
  task automatic txn(input bit d1, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int unsigned stall, input bit pend, input logic [31:0] paddr);
    logic [31:0]  exp_rd;
    logic         exp_err;
    int unsigned  n;
    int unsigned  key;
    int unsigned  lat;
    lat     = d1 ? 1 : 3;
    key     = addr >> 2;
    exp_err = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    exp_rd  = '0;
    if (!exp_err) begin
      if (we) begin
        if (d1) mdl1[key] = wdata; else mdl0[key] = wdata;
      end else if (d1) begin
        exp_rd = mdl1.exists(key) ? mdl1[key] : addr;
      end else begin
        exp_rd = mdl0.exists(key) ? mdl0[key] : addr;
      end
    end
    check("req_ready_before_accept", {31'b0, rq(d1)}, 32'd1);
    sel1      = d1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (rv(d1) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("resp_latency", n, lat);
    check("resp_valid", {31'b0, rv(d1)}, 32'd1);
    check("resp_rdata", rd(d1), exp_rd);
    check("resp_err", {31'b0, er(d1)}, {31'b0, exp_err});
    check("req_ready_busy", {31'b0, rq(d1)}, 32'd0);
    if (pend) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = paddr;
      req_wdata = '0;
    end
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rv(d1)}, 32'd1);
      check("hold_rdata", rd(d1), exp_rd);
      check("hold_err", {31'b0, er(d1)}, {31'b0, exp_err});
      check("hold_req_ready", {31'b0, rq(d1)}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_hs_valid", {31'b0, rv(d1)}, 32'd0);
    check("post_hs_rdata", rd(d1), 32'd0);
    check("post_hs_err", {31'b0, er(d1)}, 32'd0);
    check("post_hs_req_ready", {31'b0, rq(d1)}, 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(1024, 4000));
    if (r == 1) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    sel1       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", {31'b0, rq(d[0])}, 32'd1);
      check("reset_resp_valid", {31'b0, rv(d[0])}, 32'd0);
      check("reset_resp_rdata", rd(d[0]), 32'd0);
      check("reset_resp_err", {31'b0, er(d[0])}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    txn(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 5, 1'b1, 32'h44);
    txn(1'b0, 1'b0, 32'h44, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 32'h400, 32'h0, 1, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 32'h13, 32'h12345678, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      txn(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $urandom_range(0, 2), 1'b0, 32'h0);
    end

    // Reset while the read sits in its latency window: it must vanish.
    sel1      = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl0.delete();
    mdl1.delete();
    check("rst_mid_req_ready", {31'b0, req_ready0}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("rst_mid_no_resp", {31'b0, resp_valid0}, 32'd0);
      @(negedge clk);
    end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0);

    txn(1'b1, 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 0, 1'b0, 32'h0);
    txn(1'b1, 1'b0, 32'h8, 32'h0, 2, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      txn(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $urandom_range(0, 2), 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
